// File: rtl/eth_rx_loopback_fifo.sv
// Store-and-forward loopback FIFO between CMAC RX and TX AXI-Stream.
// Drops bad or overflowing frames, swaps dst/src MAC, and replays only committed frames.
module eth_rx_loopback_fifo #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = 64,
  parameter int USER_WIDTH = 17,
  parameter int DEPTH      = 64,
  parameter int MAC_SWAP   = 1
) (
  input  logic                  clk_usr_logic_in,
  input  logic                  rstn_usr_logic_in,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic [31:0]           frame_count,
  output logic [31:0]           drop_err_count,
  output logic [31:0]           drop_ovf_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SUW = USER_WIDTH - 1;
  localparam int RW  = DATA_WIDTH + KEEP_WIDTH + 1 + SUW;
  localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

  logic [RW-1:0] mem [DEPTH];

  logic [AW:0]   wr_ptr;
  logic [AW:0]   wr_commit;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   fill;
  logic          full;
  logic          ovf_flag;
  logic          resync;
  logic          accept;

  logic          avail;
  logic          out_valid;
  logic [RW-1:0] out_q;
  logic          first_beat;
  logic          handshake;
  logic          load;
  logic [DATA_WIDTH-1:0] out_data;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign fill   = wr_ptr - rd_ptr;
  assign full   = (fill == DEPTH_P);
  assign accept = s_axis_tvalid && !resync && !full && !ovf_flag;

  // After reset we may land mid-frame; CMAC RX never idles inside a frame, so an
  // idle cycle or a tlast both mark a frame boundary. A tlast-terminated partial is an overflow drop.
  always_ff @(posedge clk_usr_logic_in or negedge rstn_usr_logic_in) begin
    if (!rstn_usr_logic_in) begin
      wr_ptr         <= '0;
      wr_commit      <= '0;
      ovf_flag       <= 1'b0;
      resync         <= 1'b1;
      drop_err_count <= '0;
      drop_ovf_count <= '0;
    end else if (!s_axis_tvalid) begin
      resync <= 1'b0;
    end else if (resync) begin
      if (s_axis_tlast) begin
        resync         <= 1'b0;
        drop_ovf_count <= sat_inc(drop_ovf_count);
      end
    end else if (s_axis_tlast) begin
      if (!accept) begin
        wr_ptr         <= wr_commit;
        ovf_flag       <= 1'b0;
        drop_ovf_count <= sat_inc(drop_ovf_count);
      end else if (s_axis_tuser[0]) begin
        wr_ptr         <= wr_commit;
        drop_err_count <= sat_inc(drop_err_count);
      end else begin
        wr_ptr    <= wr_ptr + 1'b1;
        wr_commit <= wr_ptr + 1'b1;
      end
    end else if (accept) begin
      wr_ptr <= wr_ptr + 1'b1;
    end else begin
      ovf_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk_usr_logic_in) begin
    if (accept) begin
      mem[wr_ptr[AW-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser[USER_WIDTH-1:1]};
    end
  end

  assign avail     = (rd_ptr != wr_commit);
  assign handshake = out_valid && m_axis_tready;
  assign load      = avail && (!out_valid || handshake);

  // The RAM read lands directly in the output register, giving a two-cycle commit-to-valid path.
  always_ff @(posedge clk_usr_logic_in or negedge rstn_usr_logic_in) begin
    if (!rstn_usr_logic_in) begin
      rd_ptr      <= '0;
      out_valid   <= 1'b0;
      out_q       <= '0;
      first_beat  <= 1'b1;
      frame_count <= '0;
    end else begin
      if (load) begin
        out_q     <= mem[rd_ptr[AW-1:0]];
        rd_ptr    <= rd_ptr + 1'b1;
        out_valid <= 1'b1;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
      if (handshake) begin
        first_beat <= m_axis_tlast;
        if (m_axis_tlast) begin
          frame_count <= sat_inc(frame_count);
        end
      end
    end
  end

  assign out_data      = out_q[RW-1 -: DATA_WIDTH];
  assign m_axis_tkeep  = out_q[SUW+1 +: KEEP_WIDTH];
  assign m_axis_tlast  = out_q[SUW];
  assign m_axis_tuser  = {out_q[SUW-1:0], 1'b0};
  assign m_axis_tvalid = out_valid;

  // Swap is applied after the register so stalled beats stay bit-stable.
  always_comb begin
    m_axis_tdata = out_data;
    if ((MAC_SWAP != 0) && first_beat) begin
      m_axis_tdata[47:0]  = out_data[95:48];
      m_axis_tdata[95:48] = out_data[47:0];
    end
  end

endmodule

// File: tb/tb_eth_rx_loopback_fifo.sv
// Directed and randomized bench for eth_rx_loopback_fifo against a queue-based frame model.
module tb_eth_rx_loopback_fifo;

  localparam int DW    = 512;
  localparam int KW    = 64;
  localparam int UW    = 17;
  localparam int DEPTH = 64;

  logic          clk_usr_logic_in = 1'b0;
  logic          rstn_usr_logic_in;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic [UW-1:0] s_axis_tuser;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [UW-1:0] m_axis_tuser;
  logic [31:0]   frame_count;
  logic [31:0]   drop_err_count;
  logic [31:0]   drop_ovf_count;

  always #5 clk_usr_logic_in = ~clk_usr_logic_in;

  eth_rx_loopback_fifo #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .DEPTH(DEPTH), .MAC_SWAP(1)
  ) dut (
    .clk_usr_logic_in (clk_usr_logic_in),
    .rstn_usr_logic_in(rstn_usr_logic_in),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tuser     (s_axis_tuser),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tuser     (m_axis_tuser),
    .frame_count      (frame_count),
    .drop_err_count   (drop_err_count),
    .drop_ovf_count   (drop_ovf_count)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  beat_t       fifo_q[$];
  beat_t       pend_q[$];
  beat_t       exp_out;
  bit          exp_valid;
  bit          exp_ovf;
  bit          exp_resync;
  int unsigned exp_frames;
  int unsigned exp_err;
  int unsigned exp_ovfc;

  int checks    = 0;
  int passes    = 0;
  int fails     = 0;
  int dut_beats = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) d[32*i +: 32] = $urandom();
    return d;
  endfunction

  function automatic beat_t swap_mac(input beat_t b);
    beat_t r;
    r = b;
    for (int i = 0; i < 6; i++) begin
      r.data[8*i +: 8]     = b.data[8*(i+6) +: 8];
      r.data[8*(i+6) +: 8] = b.data[8*i +: 8];
    end
    return r;
  endfunction

  task automatic model_reset();
    fifo_q.delete();
    pend_q.delete();
    exp_out    = '0;
    exp_valid  = 1'b0;
    exp_ovf    = 1'b0;
    exp_resync = 1'b1;
    exp_frames = 0;
    exp_err    = 0;
    exp_ovfc   = 0;
  endtask

  // Frame-level model: committed beats wait in fifo_q, the current frame in pend_q.
  task automatic model_update();
    int    occ;
    bit    avail;
    bit    hs;
    bit    acc;
    beat_t b;
    occ   = fifo_q.size() + pend_q.size();
    avail = (fifo_q.size() != 0);
    hs    = exp_valid && m_axis_tready;
    if (hs && exp_out.last) exp_frames++;
    if ((!exp_valid || hs) && avail) begin
      exp_out   = fifo_q.pop_front();
      exp_valid = 1'b1;
    end else if (hs) begin
      exp_valid = 1'b0;
    end
    if (!s_axis_tvalid) begin
      exp_resync = 1'b0;
    end else if (exp_resync) begin
      if (s_axis_tlast) begin
        exp_ovfc++;
        exp_resync = 1'b0;
      end
    end else begin
      acc = (occ < DEPTH) && !exp_ovf;
      if (acc) begin
        b.data = s_axis_tdata;
        b.keep = s_axis_tkeep;
        b.last = s_axis_tlast;
        b.user = {s_axis_tuser[UW-1:1], 1'b0};
        pend_q.push_back(b);
      end
      if (s_axis_tlast) begin
        if (!acc) begin
          exp_ovfc++;
          exp_ovf = 1'b0;
        end else if (s_axis_tuser[0]) begin
          exp_err++;
        end else begin
          pend_q[0] = swap_mac(pend_q[0]);
          foreach (pend_q[i]) fifo_q.push_back(pend_q[i]);
        end
        pend_q.delete();
      end else if (!acc) begin
        exp_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_output();
    check("tvalid", DW'(m_axis_tvalid), DW'(exp_valid));
    if (exp_valid) begin
      check("tdata", m_axis_tdata, exp_out.data);
      check("tkeep", DW'(m_axis_tkeep), DW'(exp_out.keep));
      check("tlast", DW'(m_axis_tlast), DW'(exp_out.last));
      check("tuser", DW'(m_axis_tuser), DW'(exp_out.user));
    end
  endtask

  task automatic check_counters();
    check("frame_count", DW'(frame_count), DW'(exp_frames));
    check("drop_err_count", DW'(drop_err_count), DW'(exp_err));
    check("drop_ovf_count", DW'(drop_ovf_count), DW'(exp_ovfc));
  endtask

  task automatic check_counts_const(input int f, input int e, input int o);
    check("frame_count_const", DW'(frame_count), DW'(f));
    check("drop_err_const", DW'(drop_err_count), DW'(e));
    check("drop_ovf_const", DW'(drop_ovf_count), DW'(o));
  endtask

  task automatic check_reset_outputs();
    check("rst_tvalid", DW'(m_axis_tvalid), '0);
    check("rst_tdata", m_axis_tdata, '0);
    check("rst_tkeep", DW'(m_axis_tkeep), '0);
    check("rst_tlast", DW'(m_axis_tlast), '0);
    check("rst_tuser", DW'(m_axis_tuser), '0);
    check_counts_const(0, 0, 0);
  endtask

  // One clock: inputs already driven, model advances at the edge, outputs checked on negedge.
  task automatic step();
    if (m_axis_tvalid && m_axis_tready) dut_beats++;
    @(posedge clk_usr_logic_in);
    if (!rstn_usr_logic_in) model_reset();
    else model_update();
    @(negedge clk_usr_logic_in);
    check_output();
  endtask

  task automatic apply_stimulus(input bit v, input bit last, input bit bad, input logic [DW-1:0] d);
    s_axis_tvalid = v;
    s_axis_tlast  = last;
    s_axis_tdata  = d;
    s_axis_tkeep  = last ? 64'($urandom_range(1, 255)) : '1;
    s_axis_tuser  = {16'($urandom_range(0, 65535)), bad};
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic send_frame(input int len, input bit bad);
    for (int i = 0; i < len; i++) apply_stimulus(1'b1, i == len-1, bad && (i == len-1), rand_data());
  endtask

  initial begin
    logic [DW-1:0] d;
    int            lat;
    int            n;
    bit            bad;

    rstn_usr_logic_in = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    m_axis_tready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk_usr_logic_in);
    check_reset_outputs();
    rstn_usr_logic_in = 1'b1;
    idle(2);

    $display("[TB] good 3-beat frame with MAC swap and latency");
    d = rand_data();
    d[47:0]  = 48'h554433221100;
    d[95:48] = 48'hBBAA99887766;
    apply_stimulus(1'b1, 1'b0, 1'b0, d);
    apply_stimulus(1'b1, 1'b0, 1'b0, rand_data());
    apply_stimulus(1'b1, 1'b1, 1'b0, rand_data());
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    // Returning from the tlast step puts us one cycle past the tlast cycle.
    lat = 1;
    while (lat < 10 && !m_axis_tvalid) begin
      step();
      lat++;
    end
    check("latency", DW'(lat), DW'(2));
    check("swap_dst", DW'(m_axis_tdata[47:0]), DW'(48'hBBAA99887766));
    check("swap_src", DW'(m_axis_tdata[95:48]), DW'(48'h554433221100));
    idle(6);
    check_counts_const(1, 0, 0);

    $display("[TB] bad frame then single-beat good frame");
    dut_beats = 0;
    send_frame(2, 1'b1);
    send_frame(1, 1'b0);
    idle(6);
    check("err_beats_out", DW'(dut_beats), DW'(1));
    check_counts_const(2, 1, 0);

    $display("[TB] overflow with tready low");
    m_axis_tready = 1'b0;
    send_frame(40, 1'b0);
    send_frame(30, 1'b0);
    idle(2);
    check_counts_const(2, 1, 1);
    dut_beats = 0;
    m_axis_tready = 1'b1;
    idle(50);
    check("ovf_beats_out", DW'(dut_beats), DW'(40));
    check_counts_const(3, 1, 1);

    $display("[TB] oversized frame");
    dut_beats = 0;
    send_frame(70, 1'b0);
    idle(5);
    check("oversize_beats_out", DW'(dut_beats), DW'(0));
    check_counts_const(3, 1, 2);
    send_frame(4, 1'b0);
    idle(8);
    check("after_oversize_beats", DW'(dut_beats), DW'(4));
    check_counts_const(4, 1, 2);

    $display("[TB] random back-to-back frames with random tready");
    for (int f = 0; f < 125; f++) begin
      bad = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < 8; i++) begin
        m_axis_tready = 1'($urandom_range(0, 1));
        apply_stimulus(1'b1, i == 7, bad && (i == 7), rand_data());
      end
    end
    m_axis_tready = 1'b1;
    n = 0;
    while ((exp_valid || fifo_q.size() != 0) && n < 200) begin
      idle(1);
      n++;
    end
    check("drain_bound", DW'(n < 200), DW'(1));
    idle(2);
    check_counters();

    $display("[TB] reset mid-frame");
    send_frame(3, 1'b0);
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b0;
    rstn_usr_logic_in = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    apply_stimulus(1'b1, 1'b0, 1'b0, rand_data());
    apply_stimulus(1'b1, 1'b0, 1'b0, rand_data());
    rstn_usr_logic_in = 1'b1;
    dut_beats = 0;
    apply_stimulus(1'b1, 1'b0, 1'b0, rand_data());
    apply_stimulus(1'b1, 1'b0, 1'b0, rand_data());
    apply_stimulus(1'b1, 1'b1, 1'b0, rand_data());
    idle(3);
    check_counts_const(0, 0, 1);
    send_frame(5, 1'b0);
    idle(10);
    check("post_reset_beats", DW'(dut_beats), DW'(5));
    check_counts_const(1, 0, 1);
    check_counters();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
